// File: rtl/snn_pkg.sv
// Shared types and constants for the spike rate encoder: FSM states, default
// sizes and the LFSR polynomial/seed used by the stochastic encoding build.
package snn_pkg;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_RUN,
    ENC_DONE
  } enc_state_e;

  localparam int NUM_CH_DEFAULT  = 8;
  localparam int WIDTH_P_DEFAULT = 8;
  localparam int WINDOW_DEFAULT  = 16;

  // Fibonacci feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Frame load bus of the spike rate encoder: packed intensities handed over on
// a valid/ready handshake.
interface spike_rate_encoder_if
  import snn_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEFAULT,
  parameter int WIDTH_P = WIDTH_P_DEFAULT
);

  logic                      valid_i;
  logic                      ready_o;
  logic [NUM_CH*WIDTH_P-1:0] intensity_i;

  modport master (
    output valid_i,
    output intensity_i,
    input  ready_o
  );

  modport slave (
    input  valid_i,
    input  intensity_i,
    output ready_o
  );

endinterface

// File: rtl/spike_encoder_channel.sv
// One encoder lane: latches a channel intensity on frame load and produces the
// spike for the current timestep (accumulator carry, or LFSR compare when
// SPIKE_ENCODER_LFSR_EN is defined).
module spike_encoder_channel #(
  parameter int WIDTH_P = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH_P-1:0] intensity_i,
`ifdef SPIKE_ENCODER_LFSR_EN
  input  logic [WIDTH_P-1:0] rand_i,
`endif
  output logic               spike_o
);

  logic [WIDTH_P-1:0] intensity_q, intensity_d;

  always_comb begin
    intensity_d = intensity_q;
    if (load_i) intensity_d = intensity_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) intensity_q <= '0;
    else         intensity_q <= intensity_d;
  end

`ifdef SPIKE_ENCODER_LFSR_EN
  assign spike_o = (intensity_q > rand_i);
`else
  logic [WIDTH_P-1:0] acc_q, acc_d;
  logic [WIDTH_P:0]   sum;

  // The carry out of the phase accumulator is the spike for this step
  assign sum     = {1'b0, acc_q} + {1'b0, intensity_q};
  assign spike_o = sum[WIDTH_P];

  always_comb begin
    acc_d = acc_q;
    if (load_i)      acc_d = '0;
    else if (step_i) acc_d = sum[WIDTH_P-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end
`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// Converts one frame of intensities into WINDOW timesteps of spikes. Optional
// stochastic encoding is enabled with the SPIKE_ENCODER_LFSR_EN macro.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEFAULT,
  parameter int WIDTH_P = WIDTH_P_DEFAULT,
  parameter int WINDOW  = WINDOW_DEFAULT
`ifdef SPIKE_ENCODER_LFSR_EN
  , parameter logic [15:0] SEED = SEED_DEFAULT
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  spike_rate_encoder_if.slave       frame,
  input  logic                      step_en_i,
  input  logic                      flush_i,
  output logic [NUM_CH-1:0]         spike_o,
  output logic                      spike_valid_o,
  output logic [$clog2(WINDOW)-1:0] step_o,
  output logic                      done_o
);

  localparam int            SW        = $clog2(WINDOW);
  localparam logic [SW-1:0] LAST_STEP = SW'(WINDOW - 1);

  enc_state_e        state_q, state_d;
  logic [SW-1:0]     step_cnt_q, step_cnt_d;
  logic [SW-1:0]     step_q, step_d;
  logic [NUM_CH-1:0] spike_q, spike_d;
  logic              spike_valid_q, spike_valid_d;
  logic              load;
  logic              advance;
  logic [NUM_CH-1:0] chan_spike;

  always_comb begin
    state_d       = state_q;
    step_cnt_d    = step_cnt_q;
    step_d        = step_q;
    spike_d       = '0;
    spike_valid_d = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;
    unique case (state_q)
      ENC_IDLE: begin
        if (frame.valid_i) begin
          load       = 1'b1;
          step_cnt_d = '0;
          state_d    = ENC_RUN;
        end
      end
      ENC_RUN: begin
        if (step_en_i) begin
          advance       = 1'b1;
          spike_d       = chan_spike;
          spike_valid_d = 1'b1;
          step_d        = step_cnt_q;
          if (step_cnt_q == LAST_STEP) state_d = ENC_DONE;
          else                         step_cnt_d = step_cnt_q + 1'b1;
        end
      end
      ENC_DONE: state_d = ENC_IDLE;
      default:  state_d = ENC_IDLE;
    endcase
    // Abort wins over any load or step requested in the same cycle
    if (flush_i) begin
      state_d       = ENC_IDLE;
      step_cnt_d    = '0;
      step_d        = '0;
      spike_d       = '0;
      spike_valid_d = 1'b0;
      load          = 1'b0;
      advance       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ENC_IDLE;
      step_cnt_q    <= '0;
      step_q        <= '0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      step_q        <= step_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
    end
  end

`ifdef SPIKE_ENCODER_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] lfsr_dbl;

  // Reseeding on every accept makes a frame's spike pattern repeatable
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = SEED;
    else if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_dbl = {lfsr_q, lfsr_q};
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    spike_encoder_channel #(
      .WIDTH_P (WIDTH_P)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (load),
      .step_i      (advance),
      .intensity_i (frame.intensity_i[c*WIDTH_P +: WIDTH_P]),
`ifdef SPIKE_ENCODER_LFSR_EN
      .rand_i      (lfsr_dbl[16-c +: WIDTH_P]),
`endif
      .spike_o     (chan_spike[c])
    );
  end

  assign frame.ready_o = (state_q == ENC_IDLE);
  assign spike_o       = spike_q;
  assign spike_valid_o = spike_valid_q;
  assign step_o        = step_q;
  assign done_o        = (state_q == ENC_DONE);

endmodule
